// File: rtl/mixer_mac_sequencer.sv
// Time-multiplexed N-input weighted audio mixer. One shared 16x16 MAC is stepped over the
// snapshotted channels after each audio tick, and the mix leaves as a saturated 16-bit sample.
module mixer_mac_sequencer #(
    parameter int  N_INPUTS       = 4,
    parameter int  DEFAULT_WEIGHT = ((65536 / N_INPUTS) > 65535) ? 65535 : (65536 / N_INPUTS),
    localparam int IW             = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                     clk,
    input  logic                     I_RSTn,
    input  logic                     audio_clk_en,
    input  logic [16*N_INPUTS-1:0]   inputs_flat,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [IW-1:0]            cfg_addr,
    input  logic [15:0]              cfg_data,
    output logic [15:0]              out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int AW = 33 + $clog2(N_INPUTS);
    localparam int SW = AW - 16;
    localparam logic [15:0]          DEF_W    = 16'(DEFAULT_WEIGHT);
    localparam logic [IW-1:0]        LAST_IDX = IW'(N_INPUTS - 1);
    localparam logic signed [SW-1:0] SAT_HI   = SW'(32767);
    localparam logic signed [SW-1:0] SAT_LO   = SW'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [15:0]     out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            weight_q [N_INPUTS];
    logic signed [15:0]     snap_q   [N_INPUTS];
    logic                   snap_load;
    logic                   cfg_fire;
    logic signed [32:0]     prod;
    logic signed [SW-1:0]   acc_shr;
    logic signed [15:0]     sat_val;

    assign busy      = (state_q != S_IDLE);
    assign cfg_ready = !busy;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    // Signed sample times weight zero-extended to a positive signed operand.
    assign prod = {{17{snap_q[idx_q][15]}}, snap_q[idx_q]} * $signed({17'd0, weight_q[idx_q]});

    // Dropping the low 16 bits of a signed value is an arithmetic shift rounding toward -inf.
    assign acc_shr = acc_q[AW-1:16];

    always_comb begin
        if (acc_shr > SAT_HI) begin
            sat_val = 16'sh7FFF;
        end else if (acc_shr < SAT_LO) begin
            sat_val = -16'sh8000;
        end else begin
            sat_val = acc_shr[15:0];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        snap_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (audio_clk_en) begin
                    snap_load = 1'b1;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + AW'(prod);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_d       = sat_val;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A tick landing while busy is dropped but recorded; the set outranks a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (audio_clk_en && busy) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Out-of-range addresses match no entry, so the handshake completes without effect.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= DEF_W;
            end
        end else if (cfg_fire) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (cfg_addr == IW'(i)) begin
                    weight_q[i] <= cfg_data;
                end
            end
        end
    end

    // NOTE: the snapshot is always written before it is read, so it is left without a reset.
    always_ff @(posedge clk) begin
        if (snap_load) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                snap_q[i] <= inputs_flat[16*i +: 16];
            end
        end
    end

endmodule
